dcr_hazard_ctrl: RTL and testbench

// - Pipeline hazard/sequencing controller for the 5-stage core (IF, ID, EXE, MEM, WB).
// - Tracks destination registers in flight in EXE and MEM and drives the ID-stage forwarding selects.
// - Generates per-stage clock enables: load-use stalls, data-memory wait freezes, taken-branch/jump IF squash.

---
 rtl/dcr_pkg.sv | 43 ++++
 rtl/dcr_fwd_sel.sv | 49 ++++
 rtl/dcr_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_dcr_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dcr_pkg.sv
// ----------------------------------------------------------------------------
// dcr_pkg
// Shared types for the 5-stage core hazard/sequencing controller.
//   fwd_sel_t  : ID-stage operand forwarding select (encoding is the mux select)
//   hz_state_t : sequencing FSM state
//   sb_entry_t : one in-flight destination tracked in EXE or MEM
// Optional feature macro used by dcr_hazard_ctrl: DCR_HAZ_PERF_EN.
// ----------------------------------------------------------------------------
package dcr_pkg;

    // Register address width of the scoreboard entries. The top-level AW
    // parameter must match this value.
    localparam int DCR_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,  // register file (WB covered by write-first read)
        FWD_EXE    = 2'b01,  // ALU result currently in EXE
        FWD_MEMALU = 2'b10,  // ALU result currently in MEM
        FWD_MEMMEM = 2'b11   // load data returned in MEM
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        ERROR   = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic              memaccess;  // load or store, may stall on the data memory
        logic [DCR_AW-1:0] addr;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // Saturating 32-bit increment for the performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/dcr_fwd_sel.sv
// ----------------------------------------------------------------------------
// dcr_fwd_sel
// Combinational forwarding select for one ID-stage source operand.
// Ports:
//   uses         in  operand is actually read by the ID instruction
//   addr         in  operand register address
//   exe_*        in  EXE scoreboard entry (valid, regwrite, memread, addr)
//   mem_*        in  MEM scoreboard entry (valid, regwrite, memread, addr)
//   sel          out forwarding select (EXE has priority over MEM)
//   loaduse      out operand depends on a load still in EXE
// ----------------------------------------------------------------------------
module dcr_fwd_sel
    import dcr_pkg::*;
(
    input  logic              uses,
    input  logic [DCR_AW-1:0] addr,
    input  logic              exe_valid,
    input  logic              exe_regwrite,
    input  logic              exe_memread,
    input  logic [DCR_AW-1:0] exe_addr,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [DCR_AW-1:0] mem_addr,
    output fwd_sel_t          sel,
    output logic              loaduse
);

    logic exe_hit;
    logic mem_hit;

    // $0 is hard-wired zero, so a producer targeting it never forwards.
    assign exe_hit = uses && (addr != '0) && exe_valid && exe_regwrite && (exe_addr == addr);
    assign mem_hit = uses && (addr != '0) && mem_valid && mem_regwrite && (mem_addr == addr);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        sel = FWD_RF;
        if (exe_hit && !exe_memread) begin
            sel = FWD_EXE;
        end else if (mem_hit) begin
            sel = mem_memread ? FWD_MEMMEM : FWD_MEMALU;
        end
    end

    // A load in EXE has no data yet; the stall lets it reach MEM where it forwards 11.
    assign loaduse = exe_hit && exe_memread;

endmodule

// File: rtl/dcr_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// dcr_hazard_ctrl
// Hazard and sequencing controller for the IF/ID/EXE/MEM/WB core.
// Tracks EXE/MEM destinations, drives ID forwarding selects, and produces the
// per-stage clock enables for load-use stalls, data-memory waits and IF flush.
// Parameters: AW (register address width), MEM_TIMEOUT (max wait cycles).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   RsInID/RtInID, UsesRs/RtInID        ID source operands
//   RegWrite/MemRead/MemWriteInID       ID instruction class
//   WriteAddrInID                       ID resolved destination
//   TakenInID                           taken branch / jump in ID
//   MemReadyInMEM                       data memory completes in MEM
//   ForwardRsOutID/ForwardRtOutID       forwarding selects
//   ClkEnOutIF/ID/Back                  stage register enables
//   BubbleOutEXE, FlushOutIF            NOP insertion into ID-EXE / IF-ID
//   MemErrOut                           sticky memory timeout error
// Optional macro DCR_HAZ_PERF_EN adds saturating counters StallCntOut,
// FlushCntOut and WaitCntOut.
// ----------------------------------------------------------------------------
module dcr_hazard_ctrl
    import dcr_pkg::*;
#(
    parameter int AW          = DCR_AW,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] RsInID,
    input  logic [AW-1:0] RtInID,
    input  logic          UsesRsInID,
    input  logic          UsesRtInID,
    input  logic          RegWriteInID,
    input  logic          MemReadInID,
    input  logic          MemWriteInID,
    input  logic [AW-1:0] WriteAddrInID,
    input  logic          TakenInID,
    input  logic          MemReadyInMEM,
    output logic [1:0]    ForwardRsOutID,
    output logic [1:0]    ForwardRtOutID,
    output logic          ClkEnOutIF,
    output logic          ClkEnOutID,
    output logic          ClkEnOutBack,
    output logic          BubbleOutEXE,
    output logic          FlushOutIF,
    output logic          MemErrOut
`ifdef DCR_HAZ_PERF_EN
   ,output logic [31:0]   StallCntOut,
    output logic [31:0]   FlushCntOut,
    output logic [31:0]   WaitCntOut
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    hz_state_t state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
    logic mem_err_q, mem_err_d;
    sb_entry_t sb_exe_q, sb_exe_d;
    sb_entry_t sb_mem_q, sb_mem_d;

    fwd_sel_t fwd_rs, fwd_rt;
    logic lu_rs, lu_rt, loaduse;
    logic mem_wait;
    logic clk_en_if, clk_en_id, clk_en_back, bubble, flush;

    dcr_fwd_sel u_fwd_rs (
        .uses         (UsesRsInID),
        .addr         (DCR_AW'(RsInID)),
        .exe_valid    (sb_exe_q.valid),
        .exe_regwrite (sb_exe_q.regwrite),
        .exe_memread  (sb_exe_q.memread),
        .exe_addr     (sb_exe_q.addr),
        .mem_valid    (sb_mem_q.valid),
        .mem_regwrite (sb_mem_q.regwrite),
        .mem_memread  (sb_mem_q.memread),
        .mem_addr     (sb_mem_q.addr),
        .sel          (fwd_rs),
        .loaduse      (lu_rs)
    );

    dcr_fwd_sel u_fwd_rt (
        .uses         (UsesRtInID),
        .addr         (DCR_AW'(RtInID)),
        .exe_valid    (sb_exe_q.valid),
        .exe_regwrite (sb_exe_q.regwrite),
        .exe_memread  (sb_exe_q.memread),
        .exe_addr     (sb_exe_q.addr),
        .mem_valid    (sb_mem_q.valid),
        .mem_regwrite (sb_mem_q.regwrite),
        .mem_memread  (sb_mem_q.memread),
        .mem_addr     (sb_mem_q.addr),
        .sel          (fwd_rt),
        .loaduse      (lu_rt)
    );

    assign loaduse = lu_rs | lu_rt;

    // Access in MEM not yet completed: the whole pipeline must hold, whether
    // this is the first cycle of the access (RUN) or a later one (MEMWAIT).
    assign mem_wait     = sb_mem_q.valid && sb_mem_q.memaccess && !MemReadyInMEM;
    // The counter is zero in RUN, so +1 is this cycle's wait count in both states.
    assign wait_cnt_inc = wait_cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        clk_en_if   = 1'b1;
        clk_en_id   = 1'b1;
        clk_en_back = 1'b1;
        bubble      = 1'b0;
        flush       = 1'b0;
        case (state_q)
            ERROR: begin
                clk_en_if   = 1'b0;
                clk_en_id   = 1'b0;
                clk_en_back = 1'b0;
            end
            RUN, MEMWAIT: begin
                if (mem_wait) begin
                    clk_en_if   = 1'b0;
                    clk_en_id   = 1'b0;
                    clk_en_back = 1'b0;
                    if (wait_cnt_inc == CW'(MEM_TIMEOUT)) begin
                        state_d    = ERROR;
                        mem_err_d  = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        state_d    = MEMWAIT;
                        wait_cnt_d = wait_cnt_inc;
                    end
                end else begin
                    // Ready (or no access): behaves as RUN, so a completing wait
                    // cycle advances the pipeline in the same cycle.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (loaduse) begin
                        clk_en_if = 1'b0;
                        bubble    = 1'b1;
                    end else begin
                        flush = TakenInID;
                    end
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        sb_exe_d = sb_exe_q;
        sb_mem_d = sb_mem_q;
        if (clk_en_back) begin
            sb_mem_d = sb_exe_q;
            if (bubble) begin
                sb_exe_d = SB_EMPTY;
            end else begin
                sb_exe_d.valid     = 1'b1;
                sb_exe_d.regwrite  = RegWriteInID;
                sb_exe_d.memread   = MemReadInID;
                sb_exe_d.memaccess = MemReadInID | MemWriteInID;
                sb_exe_d.addr      = DCR_AW'(WriteAddrInID);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the two scoreboard entries are plain flops (not a RAM) and are reset, so a reset mid-access leaves nothing in flight.
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            sb_exe_q   <= SB_EMPTY;
            sb_mem_q   <= SB_EMPTY;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            sb_exe_q   <= sb_exe_d;
            sb_mem_q   <= sb_mem_d;
        end
    end

    assign ForwardRsOutID = fwd_rs;
    assign ForwardRtOutID = fwd_rt;
    assign ClkEnOutIF     = clk_en_if;
    assign ClkEnOutID     = clk_en_id;
    assign ClkEnOutBack   = clk_en_back;
    assign BubbleOutEXE   = bubble;
    assign FlushOutIF     = flush;
    assign MemErrOut      = mem_err_q;

`ifdef DCR_HAZ_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, wait_ev_cnt_q;
    logic        wait_ev;

    assign wait_ev = mem_wait && (state_q != ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            wait_ev_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= sat_inc32(stall_cnt_q, bubble);
            flush_cnt_q   <= sat_inc32(flush_cnt_q, flush);
            wait_ev_cnt_q <= sat_inc32(wait_ev_cnt_q, wait_ev);
        end
    end

    assign StallCntOut = stall_cnt_q;
    assign FlushCntOut = flush_cnt_q;
    assign WaitCntOut  = wait_ev_cnt_q;
`endif

endmodule

// File: tb/tb_dcr_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dcr_hazard_ctrl
// Directed stimulus for dcr_hazard_ctrl. Each stimulus cycle pushes its
// hand-computed expected outputs into a queue; a monitor pops one entry per
// cycle on the falling edge and compares every output field.
// Expected word packing: {fwd_rs[1:0], fwd_rt[1:0], en_if, en_id, en_back,
// bubble, flush, mem_err}.
// ----------------------------------------------------------------------------
module tb_dcr_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] RsInID = '0, RtInID = '0, WriteAddrInID = '0;
    logic       UsesRsInID = 1'b0, UsesRtInID = 1'b0;
    logic       RegWriteInID = 1'b0, MemReadInID = 1'b0, MemWriteInID = 1'b0;
    logic       TakenInID = 1'b0, MemReadyInMEM = 1'b1;
    logic [1:0] ForwardRsOutID, ForwardRtOutID;
    logic       ClkEnOutIF, ClkEnOutID, ClkEnOutBack, BubbleOutEXE, FlushOutIF, MemErrOut;
`ifdef DCR_HAZ_PERF_EN
    logic [31:0] StallCntOut, FlushCntOut, WaitCntOut;
`endif

    always #5 clk = ~clk;

    dcr_hazard_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RsInID         (RsInID),
        .RtInID         (RtInID),
        .UsesRsInID     (UsesRsInID),
        .UsesRtInID     (UsesRtInID),
        .RegWriteInID   (RegWriteInID),
        .MemReadInID    (MemReadInID),
        .MemWriteInID   (MemWriteInID),
        .WriteAddrInID  (WriteAddrInID),
        .TakenInID      (TakenInID),
        .MemReadyInMEM  (MemReadyInMEM),
        .ForwardRsOutID (ForwardRsOutID),
        .ForwardRtOutID (ForwardRtOutID),
        .ClkEnOutIF     (ClkEnOutIF),
        .ClkEnOutID     (ClkEnOutID),
        .ClkEnOutBack   (ClkEnOutBack),
        .BubbleOutEXE   (BubbleOutEXE),
        .FlushOutIF     (FlushOutIF),
        .MemErrOut      (MemErrOut)
`ifdef DCR_HAZ_PERF_EN
       ,.StallCntOut    (StallCntOut),
        .FlushCntOut    (FlushCntOut),
        .WaitCntOut     (WaitCntOut)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  exp_q[$];
    string       name_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [9:0] ex(input logic [1:0] frs, input logic [1:0] frt,
                                      input logic cif, input logic cid, input logic cbk,
                                      input logic bub, input logic fl, input logic err);
        return {frs, frt, cif, cid, cbk, bub, fl, err};
    endfunction

    localparam logic [9:0] NORM  = 10'b00_00_111_0_0_0;
    localparam logic [9:0] FROZE = 10'b00_00_000_0_0_0;

    // One pipeline cycle: drive ID inputs just after the rising edge and queue
    // the outputs expected for that cycle.
    task automatic step(input string nm, input logic rstv,
                        input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic rw, input logic mr, input logic mw,
                        input logic [4:0] wa, input logic tk, input logic rdy,
                        input logic [9:0] e);
        @(posedge clk);
        #1;
        rst_n         = rstv;
        RsInID        = rs;
        UsesRsInID    = urs;
        RtInID        = rt;
        UsesRtInID    = urt;
        RegWriteInID  = rw;
        MemReadInID   = mr;
        MemWriteInID  = mw;
        WriteAddrInID = wa;
        TakenInID     = tk;
        MemReadyInMEM = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one comparison set per queued cycle, sampled mid-cycle.
    initial begin
        logic [9:0] e;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, " fwd_rs"}, 32'(ForwardRsOutID), 32'(e[9:8]));
                check({nm, " fwd_rt"}, 32'(ForwardRtOutID), 32'(e[7:6]));
                check({nm, " en_if"},  32'(ClkEnOutIF),     32'(e[5]));
                check({nm, " en_id"},  32'(ClkEnOutID),     32'(e[4]));
                check({nm, " en_back"},32'(ClkEnOutBack),   32'(e[3]));
                check({nm, " bubble"}, 32'(BubbleOutEXE),   32'(e[2]));
                check({nm, " flush"},  32'(FlushOutIF),     32'(e[1]));
                check({nm, " mem_err"},32'(MemErrOut),      32'(e[0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //    name              rst rs urs rt urt rw mr mw wa tk rdy expected
        step("reset",           0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ex(0, 0, 1, 1, 1, 0, 1, 0));
        step("add3",            1, 0, 0, 0, 0, 1, 0, 0, 3, 0, 1, NORM);
        step("fwd_exe",         1, 3, 1, 0, 0, 1, 0, 0, 4, 0, 1, ex(1, 0, 1, 1, 1, 0, 0, 0));
        step("fwd_memalu",      1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, ex(0, 2, 1, 1, 1, 0, 0, 0));
        step("lw3",             1, 0, 0, 0, 0, 1, 1, 0, 3, 0, 1, NORM);
        step("lw3_exe",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        step("fwd_memld",       1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, ex(0, 3, 1, 1, 1, 0, 0, 0));
        step("wr0",             1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, NORM);
        step("zero_exe",        1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, NORM);
        step("zero_mem",        1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, NORM);
        // load-use: one stall cycle, then load data forwarded from MEM
        step("lw5",             1, 0, 0, 0, 0, 1, 1, 0, 5, 0, 1, NORM);
        step("loaduse",         1, 5, 1, 0, 0, 1, 0, 0, 6, 0, 1, ex(0, 0, 0, 1, 1, 1, 0, 0));
        step("loaduse_fwd",     1, 5, 1, 0, 0, 1, 0, 0, 6, 0, 1, ex(3, 0, 1, 1, 1, 0, 0, 0));
        step("after_lu",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        // flush
        step("flush",           1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ex(0, 0, 1, 1, 1, 0, 1, 0));
        step("flush_end",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        step("lw7",             1, 0, 0, 0, 0, 1, 1, 0, 7, 0, 1, NORM);
        step("flush_in_stall",  1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1, ex(0, 0, 0, 1, 1, 1, 0, 0));
        step("stall_release",   1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, ex(0, 3, 1, 1, 1, 0, 0, 0));
        // data-memory wait of 3 cycles
        step("lw8",             1, 0, 0, 0, 0, 1, 1, 0, 8, 0, 1, NORM);
        step("lw8_exe",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        for (int i = 0; i < 3; i++)
            step("memwait",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FROZE);
        step("memwait_done",    1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 1, ex(3, 0, 1, 1, 1, 0, 1, 0));
        step("run_again",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        // timeout: ready never arrives
        step("lw9",             1, 0, 0, 0, 0, 1, 1, 0, 9, 0, 1, NORM);
        step("lw9_exe",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        for (int i = 1; i <= 255; i++)
            step("timeout_wait",1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FROZE);
        step("error_state",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 1));
        step("error_sticky",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0, 1));
        step("err_reset",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        step("post_reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        // async reset in the middle of a wait
        step("lw10",            1, 0, 0, 0, 0, 1, 1, 0, 10, 0, 1, NORM);
        step("lw10_exe",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        step("wait_fwd",        1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0));
        step("async_reset",     0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
`ifdef DCR_HAZ_PERF_EN
        check("perf_stall_rst", StallCntOut, 32'd0);
        check("perf_flush_rst", FlushCntOut, 32'd0);
        check("perf_wait_rst",  WaitCntOut,  32'd0);
`endif
        step("after_abort",     1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
        step("idle",            1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);

        @(posedge clk);
        @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
